tone_period_detector: RTL and testbench
=======================================

Name: tone_period_detector

Overview:
- Receive-side counterpart of tone_generator: takes a square wave (generator output or an external pin) and recovers its switch period, high-phase length and full period in clk cycles.
- Reports tone_present once the period is stable.
- Used in loopback tests and to feed measured tones back to the control logic.

Parameters:
- TIMEOUT_CYCLES, 1000000, phase length (cycles) after which input counts as silent; must be ≤ 2^24-1
- TOLERANCE, 4, max |period - previous period| (cycles) still counted as a match
- LOCK_COUNT, 2, consecutive matches required to assert tone_present

Ports:
- clk  input  1  system clock (125 MHz)
- rst_n  input  1  asynchronous active-low reset
- square_wave_in  input  1  asynchronous square wave to measure
- switch_period  output  24  measured (high+low)>>1, same units as tone_switch_period
- high_cycles  output  24  measured high-phase length
- period_cycles  output  25  measured full period (high+low)
- period_valid  output  1  one-cycle pulse when outputs update
- tone_present  output  1  high while locked

Behaviour:
- Reset (async, rst_n=0): synchronizer flops, counters, match count, state and all outputs go to 0; state = SILENT. Reset mid-operation aborts the current measurement with no pulse.
- Front end:
  - 2-flop synchronizer, then a delay flop.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Fixed 3-cycle latency from input change to edge strobe. Measurements are therefore exact.
- Phase counter: 24 bits. Loaded to 1 on the edge that starts a phase, +1 per cycle after. Saturates at TIMEOUT_CYCLES.
- States: SILENT, HIGH, LOW.
- SILENT:
  - tone_present=0.
  - On rise → HIGH, cnt=1. Fall is ignored.
- HIGH:
  - On fall: hcap=cnt, → LOW, cnt=1.
  - Else if cnt==TIMEOUT_CYCLES → SILENT (timeout).
- LOW:
  - On rise: per=hcap+cnt (25 bits), → HIGH, cnt=1.
  - Else if cnt==TIMEOUT_CYCLES → timeout.
- On each completed period (rise in LOW):
  - First period after SILENT has no predecessor and counts as a mismatch.
  - Match = |per - prev_per| ≤ TOLERANCE. On match, matches++ (saturating). On mismatch, matches=0.
  - prev_per=per always.
  - If matches ≥ LOCK_COUNT after the update: tone_present=1; switch_period=per>>1, high_cycles=hcap, period_cycles=per; period_valid pulses for 1 cycle, 1 cycle after the rise strobe.
  - If it is a mismatch: tone_present=0; outputs hold their last values; no pulse.
- Timeout (HIGH or LOW, no edge that cycle):
  - State → SILENT, tone_present=0, matches=0, prev_per=0.
  - switch_period, high_cycles and period_cycles cleared to 0.
- Simultaneous edge and cnt==TIMEOUT_CYCLES: the edge wins and is processed normally.
- Duty cycle (volume) has no effect on switch_period; only high_cycles changes.
- Minimum measurable phase is 1 cycle; no glitch filtering.

Decomposition:
- Shared package tone_pkg: state encoding (SILENT/HIGH/LOW), PERIOD_W=24 and FULL_PERIOD_W=25 constants, shared with tone_generator.
- One sub-module edge_sync: synchronizer plus rise/fall strobes, 3-cycle latency, reset by rst_n.

Test Plan:
- Reset, square_wave_in held 0 for 2,000,000 cycles → tone_present=0, period_valid never pulses, all outputs 0.
- 50% wave, high=low=37500 cycles → after 3rd full rise (~225,003 cycles): tone_present=1, switch_period=37500, high_cycles=37500, period_cycles=75000; period_valid pulses every 75000 cycles thereafter.
- Duty change high=18750/low=56250 while locked → tone_present stays 1, switch_period=37500, high_cycles=18750.
- Step to high=low=42000, plus ±2-cycle jitter on 37500 beforehand:
  - Jitter keeps lock.
  - Step drops tone_present at the first 84000 period and re-locks 2 periods later with switch_period=42000.
- Input held 1 while locked → exactly TIMEOUT_CYCLES cycles after last rise strobe: tone_present=0, outputs 0; next rise starts a new acquisition.
- rst_n pulsed low mid-HIGH → outputs 0 immediately (async); after release, lock is re-acquired in 3 periods with no spurious period_valid.

Source files
------------

// File: rtl/tone_pkg.sv
// tone_pkg: shared state encoding, widths and helpers for the tone blocks
package tone_pkg;
    localparam int PERIOD_W      = 24;
    localparam int FULL_PERIOD_W = 25;

    typedef enum logic [1:0] {SILENT, HIGH, LOW} state_e;

    function automatic logic [FULL_PERIOD_W-1:0] abs_diff(
        input logic [FULL_PERIOD_W-1:0] a,
        input logic [FULL_PERIOD_W-1:0] b
    );
        return (a >= b) ? a - b : b - a;
    endfunction
endpackage

// File: rtl/edge_sync.sv
// edge_sync: two-flop synchronizer plus delay flop producing rise/fall strobes
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);
    logic [2:0] sync_q;

    // shift the asynchronous input through the synchronizer and delay stage
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[1:0], async_i};

    assign rise_o = sync_q[1] & ~sync_q[2];
    assign fall_o = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/tone_period_detector.sv
// tone_period_detector: measures square-wave phase lengths and reports a locked tone
module tone_period_detector
    import tone_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TOLERANCE      = 4,
    parameter int LOCK_COUNT     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     square_wave_in,
    output logic [PERIOD_W-1:0]      switch_period,
    output logic [PERIOD_W-1:0]      high_cycles,
    output logic [FULL_PERIOD_W-1:0] period_cycles,
    output logic                     period_valid,
    output logic                     tone_present
);
    logic rise, fall;

    edge_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (square_wave_in),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    state_e                   state_q, state_d;
    logic [PERIOD_W-1:0]      cnt_q, cnt_d, hcap_q, hcap_d, sw_q, sw_d, hc_q, hc_d;
    logic [FULL_PERIOD_W-1:0] prev_q, prev_d, pc_q, pc_d, per;
    logic [15:0]              m_q, m_d, m_inc;
    logic                     pv_q, pv_d, tone_q, tone_d, valid_q, valid_d;
    logic                     match, timeout, clear;

    // state and measurement registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= SILENT;
            cnt_q   <= '0;
            hcap_q  <= '0;
            prev_q  <= '0;
            pv_q    <= 1'b0;
            m_q     <= '0;
            sw_q    <= '0;
            hc_q    <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
            tone_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hcap_q  <= hcap_d;
            prev_q  <= prev_d;
            pv_q    <= pv_d;
            m_q     <= m_d;
            sw_q    <= sw_d;
            hc_q    <= hc_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            tone_q  <= tone_d;
        end

    // phase tracking, period matching and lock decision; edges take priority over timeout
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hcap_d  = hcap_q;
        prev_d  = prev_q;
        pv_d    = pv_q;
        m_d     = m_q;
        sw_d    = sw_q;
        hc_d    = hc_q;
        pc_d    = pc_q;
        valid_d = 1'b0;
        tone_d  = tone_q;
        clear   = 1'b0;
        per     = {1'b0, hcap_q} + {1'b0, cnt_q};
        timeout = cnt_q == PERIOD_W'(TIMEOUT_CYCLES);
        match   = pv_q && (abs_diff(per, prev_q) <= FULL_PERIOD_W'(TOLERANCE));
        m_inc   = match ? ((m_q == '1) ? m_q : m_q + 16'd1) : '0;
        case (state_q)
            SILENT: begin
                tone_d = 1'b0;
                if (rise) begin
                    state_d = HIGH;
                    cnt_d   = 1;
                end
            end
            HIGH: begin
                if (fall) begin
                    hcap_d  = cnt_q;
                    state_d = LOW;
                    cnt_d   = 1;
                end else if (timeout) clear = 1'b1;
                else cnt_d = cnt_q + 1'b1;
            end
            LOW: begin
                if (rise) begin
                    state_d = HIGH;
                    cnt_d   = 1;
                    prev_d  = per;
                    pv_d    = 1'b1;
                    m_d     = m_inc;
                    if (m_inc >= 16'(LOCK_COUNT)) begin
                        tone_d  = 1'b1;
                        sw_d    = per[FULL_PERIOD_W-1:1];
                        hc_d    = hcap_q;
                        pc_d    = per;
                        valid_d = 1'b1;
                    end else if (!match) tone_d = 1'b0;
                end else if (timeout) clear = 1'b1;
                else cnt_d = cnt_q + 1'b1;
            end
            default: state_d = SILENT;
        endcase
        if (clear) begin
            state_d = SILENT;
            cnt_d   = '0;
            hcap_d  = '0;
            prev_d  = '0;
            pv_d    = 1'b0;
            m_d     = '0;
            sw_d    = '0;
            hc_d    = '0;
            pc_d    = '0;
            tone_d  = 1'b0;
        end
    end

    assign switch_period = sw_q;
    assign high_cycles   = hc_q;
    assign period_cycles = pc_q;
    assign period_valid  = valid_q;
    assign tone_present  = tone_q;
endmodule

// File: tb/tb_tone_period_detector.sv
// tb_tone_period_detector: table-driven, scoreboarded check of the tone period detector
module tb_tone_period_detector;
    localparam int TMO  = 300;
    localparam int SETL = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sq = 1'b0;
    logic [23:0] switch_period, high_cycles;
    logic [24:0] period_cycles;
    logic        period_valid, tone_present;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          h;
        int          l;
        bit          pulse;
        bit          tone;
        logic [23:0] sw;
        logic [23:0] hc;
        logic [24:0] pc;
    } vec_t;

    typedef struct {
        logic [23:0] sw;
        logic [23:0] hc;
        logic [24:0] pc;
    } exp_t;

    vec_t tab[22];
    exp_t q[$];

    tone_period_detector #(
        .TIMEOUT_CYCLES (TMO),
        .TOLERANCE      (4),
        .LOCK_COUNT     (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .square_wave_in (sq),
        .switch_period  (switch_period),
        .high_cycles    (high_cycles),
        .period_cycles  (period_cycles),
        .period_valid   (period_valid),
        .tone_present   (tone_present)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // scoreboard: every period_valid pulse must match the oldest expected measurement
    always @(negedge clk) begin
        if (rst_n && period_valid) begin
            if (q.size() == 0) chk("unexpected_pulse", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("switch_period", 32'(switch_period), 32'(e.sw));
                chk("high_cycles", 32'(high_cycles), 32'(e.hc));
                chk("period_cycles", 32'(period_cycles), 32'(e.pc));
            end
        end
    end

    task automatic hold(input logic v, input int n);
        sq = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int i);
        exp_t e;
        e.sw = tab[i].sw;
        e.hc = tab[i].hc;
        e.pc = tab[i].pc;
        q.push_back(e);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tone"}, 32'(tone_present), 32'd0);
        chk({tag, "_sw"}, 32'(switch_period), 32'd0);
        chk({tag, "_hc"}, 32'(high_cycles), 32'd0);
        chk({tag, "_pc"}, 32'(period_cycles), 32'd0);
    endtask

    task automatic play(input int a, input int b);
        for (int i = a; i <= b; i++) begin
            if (i > a && tab[i-1].pulse) push(i - 1);
            hold(1'b1, tab[i].h);
            if (i > a && tab[i].h >= SETL) chk($sformatf("tone_after_%0d", i - 1), 32'(tone_present), 32'(tab[i-1].tone));
            hold(1'b0, tab[i].l);
        end
        if (tab[b].pulse) push(b);
        hold(1'b1, SETL);
        chk($sformatf("tone_after_%0d", b), 32'(tone_present), 32'(tab[b].tone));
    endtask

    initial begin
        tab[0]  = '{20, 20, 0, 0, 0, 0, 0};
        tab[1]  = '{20, 20, 0, 0, 0, 0, 0};
        tab[2]  = '{20, 20, 1, 1, 20, 20, 40};
        tab[3]  = '{10, 30, 1, 1, 20, 10, 40};
        tab[4]  = '{22, 20, 1, 1, 21, 22, 42};
        tab[5]  = '{19, 19, 1, 1, 19, 19, 38};
        tab[6]  = '{20, 23, 0, 0, 0, 0, 0};
        tab[7]  = '{22, 21, 0, 0, 0, 0, 0};
        tab[8]  = '{22, 21, 1, 1, 21, 22, 43};
        tab[9]  = '{25, 25, 0, 0, 0, 0, 0};
        tab[10] = '{25, 25, 0, 0, 0, 0, 0};
        tab[11] = '{25, 25, 1, 1, 25, 25, 50};
        tab[12] = '{1, 1, 0, 0, 0, 0, 0};
        tab[13] = '{30, 30, 0, 0, 0, 0, 0};
        tab[14] = '{30, 30, 0, 0, 0, 0, 0};
        tab[15] = '{30, 30, 1, 1, 30, 30, 60};
        tab[16] = '{40, 40, 0, 0, 0, 0, 0};
        tab[17] = '{40, 40, 0, 0, 0, 0, 0};
        tab[18] = '{40, 40, 1, 1, 40, 40, 80};
        tab[19] = '{TMO, TMO, 0, 0, 0, 0, 0};
        tab[20] = '{TMO, TMO, 0, 0, 0, 0, 0};
        tab[21] = '{TMO, TMO, 1, 1, TMO, TMO, 2 * TMO};

        repeat (3) @(posedge clk);
        #1;
        chk_zero("in_reset");
        chk("in_reset_valid", 32'(period_valid), 32'd0);
        rst_n = 1'b1;
        hold(1'b0, 2 * TMO);
        chk_zero("idle");

        play(0, 15);

        repeat (TMO + 2 - SETL) @(posedge clk);
        #1;
        chk("pre_timeout_tone", 32'(tone_present), 32'd1);
        chk("pre_timeout_sw", 32'(switch_period), 32'd30);
        @(posedge clk);
        #1;
        chk_zero("timeout");

        hold(1'b0, 10);
        play(16, 18);

        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        sq = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("after_reset");
        play(19, 21);

        repeat (10) @(posedge clk);
        #1;
        chk("pending", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
